// File: rtl/gpio_intr_ctrl.sv
// gpio_intr_ctrl: Wishbone-slave interrupt controller for 32 GPIO pins.
// Each pin is synchronized, then checked for a programmable level or edge
// condition. The result is latched into a sticky STATUS register, and one
// registered interrupt line is driven when any enabled STATUS bit is set.
module gpio_intr_ctrl #(
  parameter logic [16:0] MODULE_OFFSET     = 17'h0_2000,
  parameter logic [31:0] DEFAULT_REG_VALUE = 32'hFAB_DEF_AC
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic [16:0] WBs_ADR_i,
  input  logic        WBs_CYC_i,
  input  logic        WBs_STB_i,
  input  logic        WBs_WE_i,
  input  logic [3:0]  WBs_BYTE_STB_i,
  input  logic [31:0] WBs_DAT_i,
  output logic [31:0] WBs_DAT_o,
  output logic        WBs_ACK_o,
  input  logic [31:0] GPIO_in_i,
  output logic        GPIO_intr_o
);

  // Word offsets (byte offset >> 2)
  localparam logic [5:0] ADR_RAW    = 6'h00;
  localparam logic [5:0] ADR_TYPE   = 6'h01;
  localparam logic [5:0] ADR_POL    = 6'h02;
  localparam logic [5:0] ADR_EN     = 6'h03;
  localparam logic [5:0] ADR_STATUS = 6'h04;
  localparam logic [5:0] ADR_PEND   = 6'h05;

  logic        module_hit;
  logic        wr_en;
  logic [5:0]  word_adr;
  logic [31:0] byte_mask;
  logic [31:0] masked_dat;

  logic [31:0] sync1_reg, sync2_reg, prev_reg;
  logic [31:0] type_reg, pol_reg, en_reg, status_reg;
  logic [31:0] type_next, pol_next, en_next, status_next;
  logic [31:0] edge_event;
  logic [31:0] w1c_clear;
  logic        ack_reg;
  logic        intr_reg;

  // Byte address bits [1:0] select nothing in a 32-bit register map.
  logic unused_adr_bits;
  assign unused_adr_bits = ^WBs_ADR_i[1:0];

  assign word_adr   = WBs_ADR_i[7:2];
  assign module_hit = (WBs_ADR_i[16:8] == MODULE_OFFSET[16:8]);
  // Qualifying on ~ack makes each access write exactly once.
  assign wr_en      = module_hit & WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~ack_reg;

  genvar gi;

  // Expand the per-byte strobes to a 32-bit bit mask.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_mask
      assign byte_mask[gi*8 +: 8] = {8{WBs_BYTE_STB_i[gi]}};
    end
  endgenerate

  assign masked_dat = WBs_DAT_i & byte_mask;
  assign w1c_clear  = (wr_en && word_adr == ADR_STATUS) ? masked_dat : 32'h0;

  // Next values of the R/W configuration registers under byte strobes
  always_comb begin
    type_next = type_reg;
    pol_next  = pol_reg;
    en_next   = en_reg;
    if (wr_en) begin
      case (word_adr)
        ADR_TYPE: type_next = (type_reg & ~byte_mask) | masked_dat;
        ADR_POL:  pol_next  = (pol_reg  & ~byte_mask) | masked_dat;
        ADR_EN:   en_next   = (en_reg   & ~byte_mask) | masked_dat;
        default:  ;
      endcase
    end
  end

  // Per-pin detection. Events come only from synchronized pin history, so
  // reprogramming POL/TYPE can never fabricate an edge. In edge mode the
  // set path is checked before W1C so a coincident event is never lost.
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pin
      assign edge_event[gi] = pol_reg[gi] ? (sync2_reg[gi] & ~prev_reg[gi])
                                          : (~sync2_reg[gi] & prev_reg[gi]);
      assign status_next[gi] = !type_reg[gi] ? (sync2_reg[gi] == pol_reg[gi]) :
                               edge_event[gi] ? 1'b1 :
                               w1c_clear[gi]  ? 1'b0 :
                               status_reg[gi];
    end
  endgenerate

  // Two-flop synchronizer plus one history stage for edge detection
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      sync1_reg <= 32'h0;
      sync2_reg <= 32'h0;
      prev_reg  <= 32'h0;
    end else begin
      sync1_reg <= GPIO_in_i;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // Configuration and sticky status registers
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      type_reg   <= 32'h0;
      pol_reg    <= 32'h0;
      en_reg     <= 32'h0;
      status_reg <= 32'h0;
    end else begin
      type_reg   <= type_next;
      pol_reg    <= pol_next;
      en_reg     <= en_next;
      status_reg <= status_next;
    end
  end

  // Single-cycle acknowledge, one clock after the strobe is sampled
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      ack_reg <= 1'b0;
    end else begin
      ack_reg <= module_hit & WBs_CYC_i & WBs_STB_i & ~ack_reg;
    end
  end

  // Registered interrupt request from enabled status bits
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      intr_reg <= 1'b0;
    end else begin
      intr_reg <= |(status_reg & en_reg);
    end
  end

  // Combinational read mux; the master holds the address through ACK
  always_comb begin
    case (word_adr)
      ADR_RAW:    WBs_DAT_o = sync2_reg;
      ADR_TYPE:   WBs_DAT_o = type_reg;
      ADR_POL:    WBs_DAT_o = pol_reg;
      ADR_EN:     WBs_DAT_o = en_reg;
      ADR_STATUS: WBs_DAT_o = status_reg;
      ADR_PEND:   WBs_DAT_o = status_reg & en_reg;
      default:    WBs_DAT_o = DEFAULT_REG_VALUE;
    endcase
  end

  assign WBs_ACK_o   = ack_reg;
  assign GPIO_intr_o = intr_reg;

endmodule

// File: tb/tb_gpio_intr_ctrl.sv
// tb_gpio_intr_ctrl: directed-vector bench for gpio_intr_ctrl.
module tb_gpio_intr_ctrl;

  localparam logic [16:0] BASE  = 17'h0_2000;
  localparam logic [16:0] OTHER = 17'h0_3000;
  localparam logic [16:0] A_RAW = BASE | 17'h00;
  localparam logic [16:0] A_TYP = BASE | 17'h04;
  localparam logic [16:0] A_POL = BASE | 17'h08;
  localparam logic [16:0] A_EN  = BASE | 17'h0C;
  localparam logic [16:0] A_STS = BASE | 17'h10;
  localparam logic [16:0] A_PND = BASE | 17'h14;
  localparam logic [16:0] A_DEF = BASE | 17'h40;

  logic        WBs_CLK_i = 1'b0;
  logic        WBs_RST_i;
  logic [16:0] WBs_ADR_i;
  logic        WBs_CYC_i;
  logic        WBs_STB_i;
  logic        WBs_WE_i;
  logic [3:0]  WBs_BYTE_STB_i;
  logic [31:0] WBs_DAT_i;
  logic [31:0] WBs_DAT_o;
  logic        WBs_ACK_o;
  logic [31:0] GPIO_in_i;
  logic        GPIO_intr_o;

  int checks   = 0;
  int failures = 0;

  gpio_intr_ctrl dut (
    .WBs_CLK_i      (WBs_CLK_i),
    .WBs_RST_i      (WBs_RST_i),
    .WBs_ADR_i      (WBs_ADR_i),
    .WBs_CYC_i      (WBs_CYC_i),
    .WBs_STB_i      (WBs_STB_i),
    .WBs_WE_i       (WBs_WE_i),
    .WBs_BYTE_STB_i (WBs_BYTE_STB_i),
    .WBs_DAT_i      (WBs_DAT_i),
    .WBs_DAT_o      (WBs_DAT_o),
    .WBs_ACK_o      (WBs_ACK_o),
    .GPIO_in_i      (GPIO_in_i),
    .GPIO_intr_o    (GPIO_intr_o)
  );

  always #5 WBs_CLK_i = ~WBs_CLK_i;

  // All tasks start and end 1 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge WBs_CLK_i);
    #1;
  endtask

  task automatic wb_drive(input logic [16:0] adr, input logic we,
                          input logic [31:0] dat, input logic [3:0] bs);
    WBs_ADR_i      = adr;
    WBs_WE_i       = we;
    WBs_DAT_i      = dat;
    WBs_BYTE_STB_i = bs;
    WBs_CYC_i      = 1'b1;
    WBs_STB_i      = 1'b1;
  endtask

  task automatic wb_idle();
    WBs_CYC_i = 1'b0;
    WBs_STB_i = 1'b0;
    WBs_WE_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [16:0] adr, input logic [31:0] dat,
                          input logic [3:0] bs, output logic ack_seen);
    wb_drive(adr, 1'b1, dat, bs);
    tick(1);
    ack_seen = WBs_ACK_o;
    wb_idle();
    $display("wr adr=%h dat=%h bs=%b ack=%b", adr, dat, bs, ack_seen);
    tick(1);
  endtask

  task automatic wb_read(input logic [16:0] adr, output logic [31:0] dat,
                         output logic ack_seen);
    wb_drive(adr, 1'b0, 32'h0, 4'h0);
    tick(1);
    ack_seen = WBs_ACK_o;
    dat      = WBs_DAT_o;
    wb_idle();
    $display("rd adr=%h dat=%h ack=%b", adr, dat, ack_seen);
    tick(1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        a;
    WBs_RST_i = 1'b1;
    wb_idle();
    WBs_ADR_i = A_STS; WBs_DAT_i = 32'h0; WBs_BYTE_STB_i = 4'h0;
    GPIO_in_i = 32'h0000_FFFF;
    tick(3);
    checks++; if (WBs_ACK_o !== 1'b0) begin failures++; $display("FAIL rst_ack: got %b expected 0", WBs_ACK_o); end
    checks++; if (GPIO_intr_o !== 1'b0) begin failures++; $display("FAIL rst_intr: got %b expected 0", GPIO_intr_o); end
    checks++; if (WBs_DAT_o !== 32'h0) begin failures++; $display("FAIL rst_status: got %h expected 00000000", WBs_DAT_o); end
    WBs_ADR_i = A_RAW; #1;
    checks++; if (WBs_DAT_o !== 32'h0) begin failures++; $display("FAIL rst_raw: got %h expected 00000000", WBs_DAT_o); end
    tick(1);
    WBs_RST_i = 1'b0;
    tick(3);
    WBs_ADR_i = A_STS; #1;
    checks++; if (WBs_DAT_o !== 32'hFFFF_0000) begin failures++; $display("FAIL rst_status_3clk: got %h expected ffff0000", WBs_DAT_o); end
    tick(1);
    wb_read(A_RAW, d, a);
    checks++; if (d !== 32'h0000_FFFF || a !== 1'b1) begin failures++; $display("FAIL raw_read: got %h ack %b expected 0000ffff ack 1", d, a); end
    wb_read(A_PND, d, a);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL pend_reset: got %h expected 00000000", d); end
    wb_read(A_DEF, d, a);
    checks++; if (d !== 32'hFABDEFAC || a !== 1'b1) begin failures++; $display("FAIL default_read: got %h ack %b expected fabdefac ack 1", d, a); end
    checks++; if (GPIO_intr_o !== 1'b0) begin failures++; $display("FAIL intr_after_reset: got %b expected 0", GPIO_intr_o); end
  endtask

  task automatic test_edge_intr();
    logic [31:0] d;
    logic        a;
    wb_write(A_TYP, 32'h20, 4'hF, a);
    wb_write(A_POL, 32'h20, 4'hF, a);
    GPIO_in_i[5] = 1'b0;
    tick(4);
    wb_write(A_STS, 32'h20, 4'hF, a);
    wb_write(A_EN, 32'h20, 4'hF, a);
    wb_read(A_STS, d, a);
    checks++; if (d[5] !== 1'b0 || GPIO_intr_o !== 1'b0) begin failures++; $display("FAIL edge_idle: got sts5 %b intr %b expected 0 0", d[5], GPIO_intr_o); end
    WBs_ADR_i = A_STS;
    GPIO_in_i[5] = 1'b1;        // sampled at edge N
    tick(2);                    // N+1
    checks++; if (WBs_DAT_o[5] !== 1'b0) begin failures++; $display("FAIL edge_sts_n1: got %b expected 0", WBs_DAT_o[5]); end
    tick(1);                    // N+2
    checks++; if (WBs_DAT_o[5] !== 1'b1 || GPIO_intr_o !== 1'b0) begin failures++; $display("FAIL edge_sts_n2: got sts %b intr %b expected 1 0", WBs_DAT_o[5], GPIO_intr_o); end
    tick(1);                    // N+3
    checks++; if (GPIO_intr_o !== 1'b1) begin failures++; $display("FAIL edge_intr_n3: got %b expected 1", GPIO_intr_o); end
    wb_drive(A_STS, 1'b1, 32'h20, 4'hF);
    tick(1);                    // write edge M
    checks++; if (WBs_ACK_o !== 1'b1 || GPIO_intr_o !== 1'b1) begin failures++; $display("FAIL w1c_edge_m: got ack %b intr %b expected 1 1", WBs_ACK_o, GPIO_intr_o); end
    wb_idle();
    tick(1);                    // M+1
    checks++; if (GPIO_intr_o !== 1'b0) begin failures++; $display("FAIL w1c_intr_m1: got %b expected 0", GPIO_intr_o); end
  endtask

  task automatic test_set_wins();
    logic a;
    wb_write(A_TYP, 32'h21, 4'hF, a);
    wb_write(A_POL, 32'h21, 4'hF, a);
    wb_write(A_EN, 32'h21, 4'hF, a);
    GPIO_in_i[0] = 1'b0;
    tick(4);
    GPIO_in_i[0] = 1'b1;
    tick(4);
    checks++; if (GPIO_intr_o !== 1'b1) begin failures++; $display("FAIL bit0_first_rise: got %b expected 1", GPIO_intr_o); end
    GPIO_in_i[0] = 1'b0;
    tick(4);
    GPIO_in_i[0] = 1'b1;        // sampled at E1, status set at E3
    tick(2);
    wb_drive(A_STS, 1'b1, 32'h01, 4'hF); // W1C sampled at E3
    tick(1);
    checks++; if (WBs_ACK_o !== 1'b1 || WBs_DAT_o[0] !== 1'b1 || GPIO_intr_o !== 1'b1) begin failures++; $display("FAIL set_wins_e3: got ack %b sts0 %b intr %b expected 1 1 1", WBs_ACK_o, WBs_DAT_o[0], GPIO_intr_o); end
    wb_idle();
    tick(1);
    checks++; if (WBs_DAT_o[0] !== 1'b1 || GPIO_intr_o !== 1'b1) begin failures++; $display("FAIL set_wins_e4: got sts0 %b intr %b expected 1 1", WBs_DAT_o[0], GPIO_intr_o); end
    wb_write(A_STS, 32'h21, 4'hF, a);
    checks++; if (GPIO_intr_o !== 1'b0) begin failures++; $display("FAIL bit0_cleared: got %b expected 0", GPIO_intr_o); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic        a;
    GPIO_in_i[31] = 1'b1;
    tick(4);
    wb_read(A_STS, d, a);
    checks++; if (d[31] !== 1'b0) begin failures++; $display("FAIL level_high: got %b expected 0", d[31]); end
    GPIO_in_i[31] = 1'b0;
    tick(4);
    wb_read(A_STS, d, a);
    checks++; if (d[31] !== 1'b1) begin failures++; $display("FAIL level_low: got %b expected 1", d[31]); end
    wb_write(A_STS, 32'h8000_0000, 4'hF, a);
    wb_read(A_STS, d, a);
    checks++; if (d[31] !== 1'b1) begin failures++; $display("FAIL level_w1c_ignored: got %b expected 1", d[31]); end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] d;
    logic        a;
    wb_write(A_EN, 32'hAABB_CCDD, 4'b0101, a);
    wb_read(A_EN, d, a);
    checks++; if (d !== 32'h00BB_00DD) begin failures++; $display("FAIL en_bytes: got %h expected 00bb00dd", d); end
    wb_write(OTHER | 17'h0C, 32'hFFFF_FFFF, 4'hF, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL miss_ack: got %b expected 0", a); end
    wb_read(A_EN, d, a);
    checks++; if (d !== 32'h00BB_00DD) begin failures++; $display("FAIL miss_no_change: got %h expected 00bb00dd", d); end
    // Pins 16..31 are low and level/POL=0, so STATUS[31:16] is all ones.
    wb_read(A_PND, d, a);
    checks++; if (d !== 32'h00BB_0000) begin failures++; $display("FAIL pend_value: got %h expected 00bb0000", d); end
    checks++; if (GPIO_intr_o !== 1'b1) begin failures++; $display("FAIL pend_intr: got %b expected 1", GPIO_intr_o); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    logic        a;
    wb_drive(A_TYP, 1'b1, 32'hFFFF_FFFF, 4'hF);
    #2 WBs_RST_i = 1'b1;
    @(posedge WBs_CLK_i); #1;
    checks++; if (WBs_ACK_o !== 1'b0) begin failures++; $display("FAIL rst_mid_ack: got %b expected 0", WBs_ACK_o); end
    wb_idle();
    tick(1);
    WBs_RST_i = 1'b0;
    tick(3);
    checks++; if (GPIO_intr_o !== 1'b0) begin failures++; $display("FAIL rst_mid_intr: got %b expected 0", GPIO_intr_o); end
    wb_read(A_TYP, d, a);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_type: got %h expected 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_edge_intr();
    test_set_wins();
    test_level();
    test_byte_strobe();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
